// File: rtl/fsic_io_serdes_pkg.sv
// Shared encodings for the FSIC IO serdes lanes (tx and the matching rx).
package fsic_io_serdes_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_TRAIN = 2'd1,
    MODE_DATA  = 2'd2,
    MODE_RSVD  = 2'd3
  } serdes_mode_e;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_TRAIN = 2'd1,
    ST_DATA  = 2'd2
  } serdes_state_e;

  // Reserved mode code behaves exactly like OFF.
  function automatic serdes_state_e mode_to_state(input logic [1:0] mode);
    case (serdes_mode_e'(mode))
      MODE_TRAIN: return ST_TRAIN;
      MODE_DATA:  return ST_DATA;
      default:    return ST_OFF;
    endcase
  endfunction

endpackage

// File: rtl/fsic_sync_fifo.sv
// Single-clock word FIFO with occupancy output; pointers carry one extra wrap bit.
module fsic_sync_fifo #(
  parameter int pWIDTH = 48,
  parameter int pDEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_en_i,
  input  logic [pWIDTH-1:0]          wr_data_i,
  input  logic                       rd_en_i,
  output logic [pWIDTH-1:0]          rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(pDEPTH):0]    level_o
);

  localparam int AW = $clog2(pDEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(pDEPTH);

  logic [pWIDTH-1:0] mem_q [pDEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              push, pop;

  assign level_o   = wr_ptr_q - rd_ptr_q;
  assign full_o    = (level_o == FULL_LVL);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign push      = wr_en_i && !full_o;
  assign pop       = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance on accepted push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/fsic_io_serdes_tx_lane.sv
// FSIC IO serdes transmit lane: buffers parallel words and shifts them out
// over pLANES lanes, pCLK_RATIO ioclk phases per word.
//
// state    | meaning
// ST_OFF   | lanes idle low, serial clock gated, phase held at 0
// ST_TRAIN | training word (1 on phase 0, else 0) on every lane
// ST_DATA  | FIFO words sent; all-zero idle word when FIFO is empty
module fsic_io_serdes_tx_lane #(
  parameter int pWORD_WIDTH  = 48,
  parameter int pCLK_RATIO   = 4,
  parameter int pFIFO_DEPTH  = 4,
  localparam int pLANES      = pWORD_WIDTH / pCLK_RATIO
) (
  input  logic                          ioclk,
  input  logic                          io_rst,
  input  logic [1:0]                    cfg_mode,
  input  logic [pWORD_WIDTH-1:0]        in_word,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [pLANES-1:0]             tx_lanes,
  output logic                          tx_clk_en,
  output logic                          frame_sync,
  output logic [$clog2(pFIFO_DEPTH):0]  fifo_level,
  output logic [15:0]                   words_sent
);

  import fsic_io_serdes_pkg::*;

  localparam int PW = $clog2(pCLK_RATIO);
  localparam logic [PW-1:0] LAST_PHASE = PW'(pCLK_RATIO - 1);

  function automatic logic [pWORD_WIDTH-1:0] train_word();
    logic [pWORD_WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < pWORD_WIDTH; i++) w[i] = ((i % pCLK_RATIO) == 0);
    return w;
  endfunction

  localparam logic [pWORD_WIDTH-1:0] TRAIN_WORD = train_word();

  serdes_state_e            state_q, state_d, req_state;
  logic [PW-1:0]            phase_q, phase_d;
  logic [pWORD_WIDTH-1:0]   word_buf_q, word_buf_d;
  logic [15:0]              words_sent_q, words_sent_d;
  logic                     load, pop;
  logic                     fifo_full, fifo_empty;
  logic [pWORD_WIDTH-1:0]   fifo_head;

  // Ready is forced low while reset is held so nothing is accepted then.
  assign in_ready   = !fifo_full && !io_rst;
  assign tx_clk_en  = (state_q != ST_OFF);
  assign frame_sync = (state_q != ST_OFF) && (phase_q == '0);
  assign words_sent = words_sent_q;
  assign req_state  = mode_to_state(cfg_mode);

  fsic_sync_fifo #(
    .pWIDTH (pWORD_WIDTH),
    .pDEPTH (pFIFO_DEPTH)
  ) u_fifo (
    .clk_i     (ioclk),
    .rst_i     (io_rst),
    .wr_en_i   (in_valid && in_ready),
    .wr_data_i (in_word),
    .rd_en_i   (pop),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  // Lane j carries bit j*pCLK_RATIO+phase of the word being shifted.
  always_comb begin
    tx_lanes = '0;
    for (int j = 0; j < pLANES; j++) tx_lanes[j] = word_buf_q[j*pCLK_RATIO + int'(phase_q)];
  end

  // Next state, phase and word load; loads only at word boundaries (or leaving OFF),
  // and the loaded content is chosen by the state being entered.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    word_buf_d   = word_buf_q;
    words_sent_d = words_sent_q;
    load         = 1'b0;
    pop          = 1'b0;
    if (state_q == ST_OFF) begin
      phase_d = '0;
      load    = (req_state != ST_OFF);
    end else begin
      phase_d = (phase_q == LAST_PHASE) ? '0 : phase_q + 1'b1;
      load    = (phase_q == LAST_PHASE);
    end
    if (load) begin
      state_d = req_state;
      case (req_state)
        ST_DATA: begin
          if (!fifo_empty) begin
            word_buf_d   = fifo_head;
            pop          = 1'b1;
            words_sent_d = words_sent_q + 16'd1;
          end else begin
            word_buf_d = '0;
          end
        end
        ST_TRAIN: word_buf_d = TRAIN_WORD;
        default:  word_buf_d = '0;
      endcase
    end
  end

  // State, phase, word buffer and sent-word counter registers.
  always_ff @(posedge ioclk) begin
    if (io_rst) begin
      state_q      <= ST_OFF;
      phase_q      <= '0;
      word_buf_q   <= '0;
      words_sent_q <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      word_buf_q   <= word_buf_d;
      words_sent_q <= words_sent_d;
    end
  end

endmodule

// File: tb/tb_fsic_io_serdes_tx_lane.sv
// Bench for fsic_io_serdes_tx_lane: a receiver model rebuilds words from the
// lanes and compares them with the queue of words the bench pushed.
module tb_fsic_io_serdes_tx_lane;

  logic        ioclk = 1'b0;
  logic        io_rst = 1'b1;
  logic [1:0]  cfg_mode = 2'd0;
  logic [47:0] in_word = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] tx_lanes;
  logic        tx_clk_en;
  logic        frame_sync;
  logic [2:0]  fifo_level;
  logic [15:0] words_sent;

  int tests = 0;
  int fails = 0;
  logic [47:0] exp_q[$];
  int ws_exp = 0;

  always #5 ioclk = ~ioclk;

  fsic_io_serdes_tx_lane dut (
    .ioclk      (ioclk),
    .io_rst     (io_rst),
    .cfg_mode   (cfg_mode),
    .in_word    (in_word),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx_lanes   (tx_lanes),
    .tx_clk_en  (tx_clk_en),
    .frame_sync (frame_sync),
    .fifo_level (fifo_level),
    .words_sent (words_sent)
  );

  task automatic tick();
    @(posedge ioclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] rand_word();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[47:0] | 48'h1;
  endfunction

  // Training word from its definition: every lane is 1 on phase 0 only.
  function automatic logic [47:0] exp_train();
    logic [47:0] w;
    for (int i = 0; i < 48; i++) w[i] = ((i % 4) == 0);
    return w;
  endfunction

  task automatic push_word(input logic [47:0] w, output bit ok);
    logic r;
    ok = 1'b0;
    in_valid = 1'b1;
    in_word  = w;
    for (int k = 0; k < 64; k++) begin
      r = in_ready;
      tick();
      if (r) begin
        ok = 1'b1;
        exp_q.push_back(w);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Waits for the next frame_sync, then collects 4 phases of 12 lanes.
  task automatic recv_word(output logic [47:0] w, output bit ok);
    ok = 1'b0;
    w  = '0;
    for (int k = 0; k < 16; k++) begin
      if (frame_sync) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) begin
      for (int p = 0; p < 4; p++) begin
        if (p > 0) tick();
        for (int j = 0; j < 12; j++) w[j*4 + p] = tx_lanes[j];
      end
    end
  endtask

  task automatic expect_data(input string tag, input logic [47:0] rx);
    logic [47:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, rx, e);
      ws_exp++;
    end
  endtask

  task automatic wait_off();
    for (int k = 0; k < 12; k++) begin
      if (!tx_clk_en) break;
      tick();
    end
    check("off_timeout", tx_clk_en, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] rx, w;
    bit ok;
    int got;

    // Reset held 3 cycles with in_valid asserted
    in_valid = 1'b1;
    in_word  = rand_word();
    repeat (3) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_tx_lanes", tx_lanes, 0);
    check("rst_clk_en", tx_clk_en, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_frame_sync", frame_sync, 0);
    io_rst = 1'b0;
    in_valid = 1'b0;
    tick();
    check("post_rst_words_sent", words_sent, 0);
    check("post_rst_level", fifo_level, 0);
    check("post_rst_ready", in_ready, 1);

    // Single word in DATA
    push_word(48'h0FF0A5A5A5A5, ok);
    check("single_push_ok", ok, 1);
    check("single_level", fifo_level, 1);
    cfg_mode = 2'd2;
    recv_word(rx, ok);
    check("single_rx_ok", ok, 1);
    check("single_lane0", rx[3:0], 4'h5);
    expect_data("single_word", rx);
    check("single_words_sent", words_sent, ws_exp);
    check("single_level_after", fifo_level, 0);
    recv_word(rx, ok);
    check("idle_word", rx, 0);

    // Training, with a word parked in the FIFO meanwhile
    cfg_mode = 2'd1;
    recv_word(rx, ok);
    check("train_word0", rx, exp_train());
    w = rand_word();
    push_word(w, ok);
    check("train_push_ok", ok, 1);
    recv_word(rx, ok);
    check("train_word1", rx, exp_train());
    check("train_level_kept", fifo_level, 1);
    check("train_words_sent", words_sent, ws_exp);
    cfg_mode = 2'd2;
    recv_word(rx, ok);
    expect_data("train_to_data_word", rx);

    // Backpressure: fill in OFF, then drain while the last two words wait
    cfg_mode = 2'd0;
    wait_off();
    for (int i = 0; i < 4; i++) begin
      push_word(rand_word(), ok);
      check("bp_push_ok", ok, 1);
    end
    check("bp_full_ready", in_ready, 0);
    check("bp_full_level", fifo_level, 4);
    w = rand_word();
    in_valid = 1'b1;
    in_word  = w;
    tick();
    tick();
    check("bp_no_push_when_full", fifo_level, 4);
    cfg_mode = 2'd2;
    fork
      begin
        push_word(w, ok);
        check("bp_push5_ok", ok, 1);
        push_word(rand_word(), ok);
        check("bp_push6_ok", ok, 1);
      end
      begin
        for (int i = 0; i < 6; i++) begin
          recv_word(rx, ok);
          check("bp_rx_ok", ok, 1);
          expect_data("bp_word", rx);
        end
      end
    join
    check("bp_words_sent", words_sent, ws_exp);

    // DATA->OFF requested at phase 1 lets the word finish
    cfg_mode = 2'd0;
    wait_off();
    w = rand_word();
    push_word(w, ok);
    cfg_mode = 2'd2;
    tick();
    check("mid_frame_sync", frame_sync, 1);
    rx = '0;
    for (int p = 0; p < 4; p++) begin
      if (p > 0) tick();
      if (p == 1) cfg_mode = 2'd0;
      if (p > 1) check("mid_clk_en_held", tx_clk_en, 1);
      for (int j = 0; j < 12; j++) rx[j*4 + p] = tx_lanes[j];
    end
    expect_data("mid_word", rx);
    tick();
    check("mid_off_clk_en", tx_clk_en, 0);
    check("mid_off_lanes", tx_lanes, 0);

    // words_sent wrap from FFFE
    force dut.words_sent_q = 16'hFFFE;
    tick();
    release dut.words_sent_q;
    check("wrap_preload", words_sent, 16'hFFFE);
    push_word(rand_word(), ok);
    push_word(rand_word(), ok);
    cfg_mode = 2'd2;
    for (int i = 0; i < 2; i++) begin
      recv_word(rx, ok);
      expect_data("wrap_word", rx);
    end
    check("wrap_words_sent", words_sent, 0);
    ws_exp = 0;

    // Random pushes with random gaps; idle words are skipped by the receiver
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          repeat ($urandom_range(0, 6)) tick();
          push_word(rand_word(), ok);
          check("rand_push_ok", ok, 1);
        end
      end
      begin
        got = 0;
        for (int f = 0; f < 80 && got < 10; f++) begin
          recv_word(rx, ok);
          check("rand_rx_ok", ok, 1);
          if (rx != '0) begin
            expect_data("rand_word", rx);
            got++;
          end
        end
        check("rand_count", got, 10);
      end
    join
    check("rand_words_sent", words_sent, ws_exp);
    check("rand_level", fifo_level, 0);

    // Reset mid-word drops the word and the FIFO contents
    cfg_mode = 2'd0;
    wait_off();
    push_word(rand_word(), ok);
    push_word(rand_word(), ok);
    push_word(rand_word(), ok);
    cfg_mode = 2'd2;
    tick();
    tick();
    io_rst = 1'b1;
    tick();
    check("midrst_lanes", tx_lanes, 0);
    check("midrst_clk_en", tx_clk_en, 0);
    check("midrst_level", fifo_level, 0);
    check("midrst_ready", in_ready, 0);
    check("midrst_words_sent", words_sent, 0);
    exp_q.delete();
    io_rst = 1'b0;
    tick();
    check("postrst_clk_en", tx_clk_en, 1);
    check("postrst_idle_lanes", tx_lanes, 0);
    check("postrst_ready", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
